// File: rtl/seq_detect_arb.sv
// Round-robin shared pattern detector: NCH serial channels, one engine, per-channel context.
// Optional per-channel hit counters are built when SEQ_DETECT_ARB_HIT_CNT_EN is defined.
module seq_detect_arb #(
  parameter int                 NCH     = 4,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  localparam int                CW      = $clog2(NCH),
  localparam int                FW      = $clog2(PAT_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] flush,
  output logic [NCH-1:0] gnt,
  output logic           flag,
  output logic [CW-1:0]  flag_ch,
  input  logic [CW-1:0]  cnt_sel,
  output logic [7:0]     cnt_out,
  input  logic           cnt_clr
);

  // Handshake: a channel holds req/din until it sees its gnt bit; the bit is
  // consumed on the next falling edge while gnt is high, exactly once.
  logic [NCH-1:0]     elig;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      gidx;
  logic               any_g;
  logic [PAT_LEN-2:0] hist [NCH];
  logic [FW-1:0]      fill [NCH];
  logic [PAT_LEN-1:0] w;
  logic               match;

  assign elig = req & ~flush;

  always_comb begin
    int j;
    logic [CW-1:0] idx;
    gnt   = '0;
    gidx  = '0;
    any_g = 1'b0;
    j     = 0;
    idx   = '0;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        j = int'(ptr) + k;
        if (j >= NCH) j = j - NCH;
        idx = CW'(j);
        if (!any_g && elig[idx]) begin
          any_g    = 1'b1;
          gidx     = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  assign w     = {hist[gidx], din[gidx]};
  assign match = any_g && (w == PATTERN) && (fill[gidx] == FW'(PAT_LEN - 1));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      flag    <= 1'b0;
      flag_ch <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else begin
      flag <= match;
      if (match) flag_ch <= gidx;
      if (any_g) ptr <= (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (flush[i]) begin
          hist[i] <= '0;
          fill[i] <= '0;
        end else if (any_g && (gidx == CW'(i))) begin
          hist[i] <= w[PAT_LEN-2:0];
          if (fill[i] != FW'(PAT_LEN - 1)) fill[i] <= fill[i] + FW'(1);
        end
      end
    end
  end

`ifdef SEQ_DETECT_ARB_HIT_CNT_EN
  logic [7:0] hit_cnt [NCH];

  // Counters advance on the same edge that raises flag; clear wins.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr) hit_cnt[i] <= '0;
        else if (match && (gidx == CW'(i)) && (hit_cnt[i] != 8'hff))
          hit_cnt[i] <= hit_cnt[i] + 8'd1;
      end
    end
  end

  assign cnt_out = ({1'b0, cnt_sel} < (CW+1)'(NCH)) ? hit_cnt[cnt_sel] : 8'd0;
`else
  logic cnt_unused;
  assign cnt_unused = ^{cnt_sel, cnt_clr};
  assign cnt_out    = 8'd0;
`endif

endmodule

// File: tb/tb_seq_detect_arb.sv
// Directed bench for seq_detect_arb (4 channels, pattern 1101); state changes on negedge,
// so inputs are driven and outputs sampled just after each rising edge.
module tb_seq_detect_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, din, flush, gnt;
  logic       flag;
  logic [1:0] flag_ch, cnt_sel;
  logic [7:0] cnt_out;
  logic       cnt_clr;

  int tests = 0;
  int fails = 0;

  seq_detect_arb #(.NCH(4), .PAT_LEN(4), .PATTERN(4'b1101)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .flush(flush), .gnt(gnt),
    .flag(flag), .flag_ch(flag_ch), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One falling (consume) edge, then park just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] ch, input logic b);
    req = 4'b0001 << ch;
    din = '0;
    din[ch] = b;
    tick();
    req = '0;
    din = '0;
  endtask

  task automatic send(input logic [1:0] ch, input logic b, input logic exp_flag, input string tag);
    logic [3:0] eg;
    eg = 4'b0001 << ch;
    req = eg;
    din = '0;
    din[ch] = b;
    #1;
    chk({tag, "_gnt"}, gnt, eg);
    tick();
    req = '0;
    din = '0;
    chk({tag, "_flag"}, flag, exp_flag);
    if (exp_flag) chk({tag, "_ch"}, flag_ch, ch);
  endtask

  initial begin
    logic [6:0] bits;
    logic [6:0] flg;
    rst = 1'b1; req = '0; din = '0; flush = '0; cnt_sel = '0; cnt_clr = 1'b0;

    // Reset state
    @(posedge clk); #1;
    req = 4'b1111; din = 4'b1111; #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_flag", flag, 1'b0);
    chk("rst_flag_ch", flag_ch, 2'd0);
    chk("rst_cnt", cnt_out, 8'd0);
    tick();
    chk("rst_gnt_hold", gnt, 4'b0000);
    req = '0; din = '0; rst = 1'b0;

    // Test 1: reset mid-stream with ch0 fill=3
    send(2'd0, 1'b1, 1'b0, "t1_pre0");
    send(2'd0, 1'b1, 1'b0, "t1_pre1");
    send(2'd0, 1'b0, 1'b0, "t1_pre2");
    rst = 1'b1; req = 4'b0001; din = 4'b0001; #1;
    chk("t1_rst_gnt", gnt, 4'b0000);
    chk("t1_rst_flag", flag, 1'b0);
    tick();
    chk("t1_rst_flag2", flag, 1'b0);
    rst = 1'b0; req = '0; din = '0;
    send(2'd0, 1'b1, 1'b0, "t1_b0");
    send(2'd0, 1'b1, 1'b0, "t1_b1");
    send(2'd0, 1'b0, 1'b0, "t1_b2");
    send(2'd0, 1'b1, 1'b1, "t1_b3");
    tick();
    chk("t1_pulse_end", flag, 1'b0);

    // Test 2: ch2 alone, 1101101 -> hits after bits 4 and 7
    bits = 7'b1101101;
    flg  = 7'b0001001;
    for (int i = 6; i >= 0; i--) send(2'd2, bits[i], flg[i], "t2");

    // Test 3: all request; ptr is steered to 0 first via a ch3 grant
    send(2'd3, 1'b0, 1'b0, "t3_pre");
    req = 4'b1111; din = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_rr_gnt", gnt, 4'b0001 << (k % 4));
      tick();
      chk("t3_rr_flag", flag, 1'b0);
    end
    req = '0;
    flush = 4'b1111;
    tick();
    flush = '0;

    // Test 4: interleaved ch0/ch1 contexts stay separate
    send(2'd0, 1'b1, 1'b0, "t4_c0a");
    send(2'd1, 1'b1, 1'b0, "t4_c1a");
    send(2'd0, 1'b1, 1'b0, "t4_c0b");
    send(2'd1, 1'b1, 1'b0, "t4_c1b");
    send(2'd0, 1'b0, 1'b0, "t4_c0c");
    send(2'd1, 1'b0, 1'b0, "t4_c1c");
    send(2'd1, 1'b1, 1'b1, "t4_c1d");
    tick();
    chk("t4_idle_flag", flag, 1'b0);
    chk("t4_idle_ch_hold", flag_ch, 2'd1);
    send(2'd0, 1'b1, 1'b1, "t4_c0d");

    // Test 5: flush on ch3 mid-pattern
    send(2'd3, 1'b1, 1'b0, "t5_a");
    send(2'd3, 1'b1, 1'b0, "t5_b");
    send(2'd3, 1'b0, 1'b0, "t5_c");
    req = 4'b1000; din = 4'b1000; flush = 4'b1000; #1;
    chk("t5_flush_gnt", gnt, 4'b0000);
    tick();
    chk("t5_flush_flag", flag, 1'b0);
    req = '0; din = '0; flush = '0;
    send(2'd3, 1'b1, 1'b0, "t5_d");
    send(2'd3, 1'b1, 1'b0, "t5_e");
    send(2'd3, 1'b0, 1'b0, "t5_f");
    send(2'd3, 1'b1, 1'b1, "t5_g");

`ifdef SEQ_DETECT_ARB_HIT_CNT_EN
    // Test 6: hit counters (ch0=2, ch1=1, ch2=2, ch3=1 so far)
    cnt_sel = 2'd0; #1; chk("t6_cnt0", cnt_out, 8'd2);
    cnt_sel = 2'd2; #1; chk("t6_cnt2", cnt_out, 8'd2);
    cnt_sel = 2'd3; #1; chk("t6_cnt3", cnt_out, 8'd1);
    flush = 4'b0010;
    tick();
    flush = '0;
    feed(2'd1, 1'b1); feed(2'd1, 1'b1); feed(2'd1, 1'b0); feed(2'd1, 1'b1);
    for (int n = 0; n < 253; n++) begin
      feed(2'd1, 1'b1); feed(2'd1, 1'b0); feed(2'd1, 1'b1);
    end
    cnt_sel = 2'd1; #1; chk("t6_cnt1_255", cnt_out, 8'd255);
    for (int n = 0; n < 50; n++) begin
      feed(2'd1, 1'b1); feed(2'd1, 1'b0); feed(2'd1, 1'b1);
    end
    chk("t6_cnt1_sat", cnt_out, 8'd255);
    feed(2'd1, 1'b1); feed(2'd1, 1'b0);
    cnt_clr = 1'b1;
    feed(2'd1, 1'b1);
    cnt_clr = 1'b0;
    chk("t6_clr_flag", flag, 1'b1);
    cnt_sel = 2'd1; #1; chk("t6_clr_cnt1", cnt_out, 8'd0);
    cnt_sel = 2'd2; #1; chk("t6_clr_cnt2", cnt_out, 8'd0);
    feed(2'd1, 1'b1); feed(2'd1, 1'b0); feed(2'd1, 1'b1);
    cnt_sel = 2'd1; #1; chk("t6_after_clr", cnt_out, 8'd1);
`else
    cnt_sel = 2'd2; cnt_clr = 1'b1; #1;
    chk("t6_nocnt_a", cnt_out, 8'd0);
    cnt_clr = 1'b0; cnt_sel = 2'd3; #1;
    chk("t6_nocnt_b", cnt_out, 8'd0);
`endif

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
